dm_responder: RTL

Data-memory responder that services the load/store requests issued by the processor's EX stage over a req/ack handshake. It holds a word-addressed RAM, inserts a parameterised number of wait states, and returns read data with a single-cycle acknowledge. It sits beside the EX stage as the target end of the data-memory interface, replacing the zero-latency memory model.

---
 rtl/dm_pkg.sv | 13 +
 rtl/dm_wait_ctr.sv | 26 ++
 rtl/dm_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared types and widths for the data-memory responder.
package dm_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dm_wait_ctr.sv
// Loadable down-counter for wait-state insertion; holds at zero and flags it.
module dm_wait_ctr
  import dm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: word RAM behind a req/ack handshake with WAIT_CYCLES wait states.
// Optional misaligned-access flagging is enabled by defining MISALIGN_CHECK_EN.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t state, state_nxt;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_idx;
  logic [WORD_W-1:0] lat_wdata;
  logic              lat_mis;

  logic              cur_mis;
  logic              accept;
  logic              enter_resp;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_idx;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_mis;

  logic [WORD_W-1:0] mem [DEPTH];

`ifdef MISALIGN_CHECK_EN
  assign cur_mis = (addr[1:0] != 2'b00);
  logic unused_addr;
  assign unused_addr = ^addr[WORD_W-1:ADDR_W+2];
`else
  assign cur_mis = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{addr[WORD_W-1:ADDR_W+2], addr[1:0]};
`endif

  dm_wait_ctr u_wait_ctr (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (CNT_INIT),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_load  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With no wait states the RAM is accessed on the acceptance edge itself,
  // so the live request payload is used instead of the not-yet-latched copy.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = we;
      acc_idx   = addr[ADDR_W+1:2];
      acc_wdata = wdata;
      acc_mis   = cur_mis;
    end else begin
      acc_we    = lat_we;
      acc_idx   = lat_idx;
      acc_wdata = lat_wdata;
      acc_mis   = lat_mis;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_mis   <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_we    <= we;
        lat_idx   <= addr[ADDR_W+1:2];
        lat_wdata <= wdata;
        lat_mis   <= cur_mis;
      end
      err <= enter_resp && acc_mis;
      if (enter_resp && !acc_we && !acc_mis) begin
        rdata <= mem[acc_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && enter_resp && acc_we && !acc_mis) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign ack  = (state == RESP);
  assign busy = (state != IDLE);

endmodule
